// File: rtl/pcie_strm_arb_if.sv
// Stream-side and output-side handshake bundle for pcie_strm_arb.
// Field names keep the _i/_o suffixes of the arbiter's own view.
interface pcie_strm_arb_if #(
  parameter int NUM_STRM   = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int CH_W = (NUM_STRM > 1) ? $clog2(NUM_STRM) : 1;

  logic [NUM_STRM-1:0]            strm_data_valid_i;
  logic [NUM_STRM*DATA_WIDTH-1:0] strm_data_i;
  logic [NUM_STRM-1:0]            strm_ack_o;
  logic [NUM_STRM-1:0]            chan_en_i;
  logic                           out_data_valid_o;
  logic [DATA_WIDTH-1:0]          out_data_o;
  logic [CH_W-1:0]                out_chan_o;
  logic                           out_last_o;
  logic                           out_ack_i;

  modport slave (
    input  strm_data_valid_i,
    input  strm_data_i,
    input  chan_en_i,
    input  out_ack_i,
    output strm_ack_o,
    output out_data_valid_o,
    output out_data_o,
    output out_chan_o,
    output out_last_o
  );

  modport master (
    output strm_data_valid_i,
    output strm_data_i,
    output chan_en_i,
    output out_ack_i,
    input  strm_ack_o,
    input  out_data_valid_o,
    input  out_data_o,
    input  out_chan_o,
    input  out_last_o
  );
endinterface

// File: rtl/pcie_strm_arb.sv
// Round-robin burst arbiter merging NUM_STRM streams into one output.
// Optional per-stream beat counters: define STRM_ARB_STATS_EN.
module pcie_strm_arb #(
  parameter int NUM_STRM   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                  pcie_core_clk,
  input  logic                  user_reset,
  pcie_strm_arb_if.slave        bus,
  input  logic                  stats_clr_i,
  output logic [NUM_STRM*32-1:0] beat_cnt_o
);

  localparam int CH_W = (NUM_STRM > 1) ? $clog2(NUM_STRM) : 1;
  localparam int BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       last_q, last_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic [CH_W-1:0]       oc_q, oc_d;
  logic                  ol_q, ol_d;

  logic [NUM_STRM-1:0]   req;
  logic [NUM_STRM-1:0]   ack;
  logic [NUM_STRM-1:0]   ack_o;
  logic [CH_W-1:0]       pick;
  logic                  found;
  logic                  g_req;
  logic                  room;
  logic                  burst_end;
  int                    idx;

  assign req       = bus.strm_data_valid_i & bus.chan_en_i;
  assign g_req     = req[grant_q];
  assign room      = ~ov_q | bus.out_ack_i;
  assign burst_end = (bcnt_q == BW'(BURST_LEN - 1));

  // Search starts one past the previous grant so every stream gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_STRM; i++) begin
      idx = (int'(last_q) + i) % NUM_STRM;
      if (!found && req[CH_W'(idx)]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    ack     = '0;
    ov_d    = ov_q & ~bus.out_ack_i;
    od_d    = od_q;
    oc_d    = oc_q;
    ol_d    = ol_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          bcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!g_req) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (room) begin
          ack[grant_q] = 1'b1;
          ov_d   = 1'b1;
          od_d   = bus.strm_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
          oc_d   = grant_q;
          ol_d   = burst_end;
          bcnt_d = bcnt_q + BW'(1);
          if (burst_end) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcie_core_clk) begin
    if (user_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CH_W'(NUM_STRM - 1);
      bcnt_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      oc_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      oc_q    <= oc_d;
      ol_q    <= ol_d;
    end
  end

  // Accepts are suppressed while reset is held so no beat is lost upstream.
  assign ack_o                = ack & {NUM_STRM{~user_reset}};
  assign bus.strm_ack_o       = ack_o;
  assign bus.out_data_valid_o = ov_q;
  assign bus.out_data_o       = od_q;
  assign bus.out_chan_o       = oc_q;
  assign bus.out_last_o       = ol_q;

`ifdef STRM_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_STRM];

  always_ff @(posedge pcie_core_clk) begin
    for (int k = 0; k < NUM_STRM; k++) begin
      if (user_reset || stats_clr_i) begin
        cnt_q[k] <= '0;
      end else if (ack_o[k]) begin
        cnt_q[k] <= cnt_q[k] + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_STRM; k++) begin : g_cnt
    assign beat_cnt_o[k*32 +: 32] = cnt_q[k];
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign beat_cnt_o       = '0;
`endif

endmodule
